piece_drop: RTL and testbench

PIECE_DROP -- requirements
Module: piece_drop

---
 rtl/connect4_pkg.sv | 31 +++
 rtl/piece_drop_if.sv | 23 ++
 rtl/c4_board_regs.sv | 47 ++++
 rtl/piece_drop.sv | 121 ++++++++++++
 tb/tb_piece_drop.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/connect4_pkg.sv
// Shared constants and types for the Connect-4 piece drop unit.
// Board geometry, cell encoding and drop-FSM states.
package connect4_pkg;

  localparam int         NUM_ROWS  = 6;
  localparam int         NUM_COLS  = 7;
  localparam int         NUM_CELLS = NUM_ROWS * NUM_COLS;
  localparam logic [2:0] COL_NONE  = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WRITE,
    REPORT,
    REJECT
  } drop_st_t;

  function automatic logic on_board(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return (r < 3'(NUM_ROWS)) && (c < 3'(NUM_COLS));
  endfunction

endpackage

// File: rtl/piece_drop_if.sv
// Drop request / result bundle between the game controller
// and the piece drop unit.
interface piece_drop_if;

  logic       drop;
  logic [2:0] colval;
  logic       busy;
  logic       done;
  logic       invalid;
  logic [2:0] row_out;
  logic [2:0] col_out;

  modport master (
    output drop, colval,
    input  busy, done, invalid, row_out, col_out
  );

  modport slave (
    input  drop, colval,
    output busy, done, invalid, row_out, col_out
  );

endinterface

// File: rtl/c4_board_regs.sv
// 6x7 board storage: one write port, a scan read port
// and a display read port, with synchronous clear.
module c4_board_regs
  import connect4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  cell_t      wr_data,
  input  logic [2:0] sc_row,
  input  logic [2:0] sc_col,
  output cell_t      sc_cell,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output cell_t      rd_cell
);

  cell_t cells [NUM_ROWS][NUM_COLS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < NUM_COLS; c++)
          cells[r][c] <= EMPTY;
    end else if (clr) begin
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < NUM_COLS; c++)
          cells[r][c] <= EMPTY;
    end else if (we && on_board(wr_row, wr_col)) begin
      cells[wr_row][wr_col] <= wr_data;
    end
  end

  // Off-board addresses read as empty.
  always_comb begin
    sc_cell = EMPTY;
    rd_cell = EMPTY;
    if (on_board(sc_row, sc_col))
      sc_cell = cells[sc_row][sc_col];
    if (on_board(rd_row, rd_col))
      rd_cell = cells[rd_row][rd_col];
  end

endmodule

// File: rtl/piece_drop.sv
// Connect-4 piece drop: scans a column bottom-up, places the
// mover's piece in the first empty cell and reports it.
module piece_drop
  import connect4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  piece_drop_if.slave bus,
  output logic        player,
  output logic        board_full,
  input  logic [2:0]  rd_row,
  input  logic [2:0]  rd_col,
  output logic [1:0]  rd_cell
);

  drop_st_t   st, nxt;
  logic [2:0] col_q, row_q;
  logic [2:0] row_o, col_o;
  logic [5:0] cnt;
  logic       ply;
  logic       take;
  logic       we, busy, done, invalid;
  cell_t      sc_cell, dp_cell;

  assign board_full = (cnt == 6'(NUM_CELLS));
  assign take = bus.drop && (bus.colval != COL_NONE)
             && !board_full;

  c4_board_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .we      (we),
    .wr_row  (row_q),
    .wr_col  (col_q),
    .wr_data (ply ? P2 : P1),
    .sc_row  (row_q),
    .sc_col  (col_q),
    .sc_cell (sc_cell),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_cell (dp_cell)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:
        if (bus.drop) nxt = take ? SCAN : REJECT;
      SCAN:
        if (sc_cell == EMPTY)
          nxt = WRITE;
        else if (row_q == 3'(NUM_ROWS - 1))
          nxt = REJECT;
      WRITE:   nxt = REPORT;
      REPORT:  nxt = IDLE;
      REJECT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  always_comb begin
    busy    = (st != IDLE);
    done    = (st == REPORT);
    invalid = (st == REJECT);
    we      = (st == WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      row_o <= '0;
      col_o <= '0;
      cnt   <= '0;
      ply   <= 1'b0;
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
      row_o <= '0;
      col_o <= '0;
      cnt   <= '0;
      ply   <= 1'b0;
    end else begin
      unique case (st)
        IDLE:
          if (take) begin
            col_q <= bus.colval;
            row_q <= '0;
          end
        SCAN:
          if (sc_cell != EMPTY &&
              row_q != 3'(NUM_ROWS - 1))
            row_q <= row_q + 3'd1;
        WRITE: begin
          row_o <= row_q;
          col_o <= col_q;
          cnt   <= cnt + 6'd1;
          ply   <= ~ply;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.invalid = invalid;
  assign bus.row_out = row_o;
  assign bus.col_out = col_o;
  assign player      = ply;
  assign rd_cell     = dp_cell;

endmodule

// File: tb/tb_piece_drop.sv
// Bench for piece_drop: column-height model checked every cycle
// plus directed drops with hand-computed results.
module tb_piece_drop;
  import connect4_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       player, board_full;
  logic [2:0] rd_row = '0;
  logic [2:0] rd_col = '0;
  logic [1:0] rd_cell;

  piece_drop_if bus ();

  piece_drop dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .bus        (bus),
    .player     (player),
    .board_full (board_full),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_cell    (rd_cell)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Model: column heights and a countdown of busy cycles.
  int m_grid [6][7];
  int m_h [7];
  int m_count = 0;
  int m_player = 0;
  int m_row = 0;
  int m_col = 0;
  int m_rem = 0;
  bit m_isdone = 0;
  int m_lrow = 0;
  int m_lcol = 0;

  task mreset();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        m_grid[r][c] = 0;
    for (int c = 0; c < 7; c++) m_h[c] = 0;
    m_count = 0; m_player = 0;
    m_row = 0; m_col = 0; m_rem = 0;
  endtask

  function automatic int mcell(int r, int c);
    if (r < 6 && c < 7) return m_grid[r][c];
    return 0;
  endfunction

  initial mreset();

  always @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      mreset();
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 1 && m_isdone) begin
        m_grid[m_lrow][m_lcol] = m_player + 1;
        m_h[m_lcol]++;
        m_count++;
        m_row = m_lrow;
        m_col = m_lcol;
        m_player ^= 1;
      end
    end else if (bus.drop) begin
      int c;
      c = int'(bus.colval);
      if (c == 7 || m_count == 42) begin
        m_rem = 1; m_isdone = 0;
      end else if (m_h[c] == 6) begin
        m_rem = 7; m_isdone = 0;
      end else begin
        m_rem = m_h[c] + 3; m_isdone = 1;
        m_lrow = m_h[c]; m_lcol = c;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", bus.busy, m_rem > 0);
      chk("done", bus.done, m_rem == 1 && m_isdone);
      chk("invalid", bus.invalid,
          m_rem == 1 && !m_isdone);
      chk("exclusive", bus.done & bus.invalid, 0);
      chk("player", player, m_player);
      chk("board_full", board_full, m_count == 42);
      chk("row_out", bus.row_out, m_row);
      chk("col_out", bus.col_out, m_col);
      chk("rd_cell", rd_cell,
          mcell(int'(rd_row), int'(rd_col)));
      if (bus.done) done_cnt++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_at(input logic [2:0] c,
                         input int exp_lat,
                         input bit exp_done);
    int lat;
    bit isd;
    bus.drop = 1'b1;
    bus.colval = c;
    step();
    bus.drop = 1'b0;
    bus.colval = COL_NONE;
    lat = 0;
    isd = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.invalid) begin
        lat = i;
        isd = bus.done;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL drop_timeout: got none expected lat %0d",
               exp_lat);
    end else begin
      chk("latency", lat, exp_lat);
      chk("outcome", isd, exp_done);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int d0;
    bus.drop = 1'b0;
    bus.colval = COL_NONE;
    #2 rst = 1'b0;
    #1 chk_en = 1;
    step(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_player", player, 0);
    chk("rst_full", board_full, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b1;
    step();

    // First drop lands at the bottom of column 3.
    rd_row = 3'd0; rd_col = 3'd3;
    drop_at(3'd3, 3, 1);
    chk("d1_row", bus.row_out, 0);
    chk("d1_col", bus.col_out, 3);
    chk("d1_cell", rd_cell, 2'b01);
    chk("d1_player", player, 1);
    resync();

    // Stack column 0 to the top, then overfill.
    do_clr();
    for (int r = 0; r < 6; r++) begin
      rd_row = 3'(r); rd_col = 3'd0;
      drop_at(3'd0, r + 3, 1);
      chk("c0_row", bus.row_out, r);
      chk("c0_cell", rd_cell, (r % 2) ? 2 : 1);
      chk("c0_player", player, (r % 2) ? 0 : 1);
      resync();
    end
    rd_row = 3'd5;
    drop_at(3'd0, 7, 0);
    chk("c0_full_player", player, 0);
    chk("c0_full_top", rd_cell, 2'b10);
    resync();

    // No column selected.
    drop_at(COL_NONE, 1, 0);
    chk("none_player", player, 0);
    resync();

    // Drop held high while busy gives one placement.
    d0 = done_cnt;
    bus.drop = 1'b1;
    bus.colval = 3'd1;
    step(4);
    bus.drop = 1'b0;
    bus.colval = COL_NONE;
    step(6);
    chk("busy_one_done", done_cnt - d0, 1);

    // Clear wins over a simultaneous drop.
    clr = 1'b1;
    bus.drop = 1'b1;
    bus.colval = 3'd2;
    step();
    clr = 1'b0;
    bus.drop = 1'b0;
    bus.colval = COL_NONE;
    d0 = done_cnt;
    step(5);
    chk("clr_no_done", done_cnt - d0, 0);
    rd_row = 3'd0; rd_col = 3'd1;
    #1 chk("clr_empty", rd_cell, 0);

    // Fill the whole board column by column.
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        drop_at(3'(c), r + 3, 1);
        resync();
      end
    chk("full_flag", board_full, 1);
    drop_at(3'd4, 1, 0);
    resync();
    for (int a = 0; a < 64; a++) begin
      rd_row = 3'(a % 8);
      rd_col = 3'(a / 8);
      step();
    end
    rd_row = 3'd5; rd_col = 3'd6;
    #1 chk("full_5_6", rd_cell, 2'b10);
    rd_row = 3'd0; rd_col = 3'd0;
    #1 chk("full_0_0", rd_cell, 2'b01);
    rd_row = 3'd7;
    #1 chk("offboard", rd_cell, 0);

    // Reset in the middle of a column scan.
    do_clr();
    for (int i = 0; i < 3; i++) begin
      drop_at(3'd5, i + 3, 1);
      resync();
    end
    bus.drop = 1'b1;
    bus.colval = 3'd5;
    step();
    bus.drop = 1'b0;
    bus.colval = COL_NONE;
    step();
    chk("scan_busy", bus.busy, 1);
    rst = 1'b0;
    rd_row = 3'd0; rd_col = 3'd5;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_inv", bus.invalid, 0);
    chk("arst_player", player, 0);
    chk("arst_row", bus.row_out, 0);
    chk("arst_col", bus.col_out, 0);
    chk("arst_full", board_full, 0);
    chk("arst_cell", rd_cell, 0);
    step(2);
    rst = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
